// File: rtl/audio_sequencer.sv
// audio_sequencer: CHANNELS independent note players sharing one note memory port.
// A tempo tick marks channels pending; a 3-cycle fetch FSM serves them lowest index first.
`default_nettype none

module audio_sequencer #(
  parameter int CHANNELS = 4,
  parameter int NOTE_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int LEN_W    = 8,
  parameter int DIV_W    = 25
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [DIV_W-1:0]           TempoDiv,
  input  logic                       CfgWe,
  input  logic [2:0]                 CfgChan,
  input  logic [ADDR_W-1:0]          CfgBase,
  input  logic [LEN_W-1:0]           CfgLen,
  input  logic                       CfgLoop,
  input  logic [CHANNELS-1:0]        Start,
  input  logic [CHANNELS-1:0]        Stop,
  output logic                       MemRd,
  output logic [ADDR_W-1:0]          MemAddr,
  input  logic [NOTE_W-1:0]          MemData,
  output logic [CHANNELS*NOTE_W-1:0] Note,
  output logic [CHANNELS-1:0]        NoteStrobe,
  output logic [CHANNELS-1:0]        Busy,
  output logic [CHANNELS-1:0]        Done
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [LEN_W:0] POS_ONE = (LEN_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    sel, sel_nxt, low_idx;
  logic                fetch_kill;

  logic [DIV_W-1:0]    cnt;
  logic                tick;

  logic [ADDR_W-1:0]   cfg_base [CHANNELS];
  logic [LEN_W-1:0]    cfg_len  [CHANNELS];
  logic [CHANNELS-1:0] cfg_loop;
  logic [ADDR_W-1:0]   act_base [CHANNELS];
  logic [LEN_W-1:0]    act_len  [CHANNELS];
  logic [CHANNELS-1:0] act_loop;
  logic [LEN_W:0]      pos      [CHANNELS];
  logic [NOTE_W-1:0]   note     [CHANNELS];

  logic [CHANNELS-1:0] pending, pend_nxt, go, kill, capture, advance;
  logic [ADDR_W-1:0]   addr_sum;

  assign tick = (cnt >= TempoDiv);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + DIV_W'(1);
  end

  // A kill (Stop or accepted Start) overrides any tick or capture in the same cycle.
  always_comb begin
    go       = '0;
    kill     = '0;
    capture  = '0;
    advance  = '0;
    pend_nxt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      go[c]      = Start[c] & ~Stop[c] & (cfg_len[c] != '0);
      kill[c]    = Stop[c] | go[c];
      capture[c] = (state == CAPTURE) && (sel == SEL_W'(c)) && !fetch_kill;
      advance[c] = tick & Busy[c] & ~pending[c];
      if (Stop[c])
        pend_nxt[c] = 1'b0;
      else if (go[c])
        pend_nxt[c] = tick;
      else
        pend_nxt[c] = (pending[c] & ~capture[c]) |
                      (advance[c] & ((pos[c] < {1'b0, act_len[c]}) | act_loop[c]));
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_nxt[i]) low_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (|pend_nxt) begin
          state_nxt = ISSUE;
          sel_nxt   = low_idx;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      sel        <= '0;
      fetch_kill <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      if (state == ISSUE) fetch_kill <= kill[sel];
    end
  end

  assign addr_sum = act_base[sel] + ADDR_W'(pos[sel]);
  assign MemRd    = (state == ISSUE);
  assign MemAddr  = (state == ISSUE) ? addr_sum : '0;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pending    <= '0;
      NoteStrobe <= '0;
      Done       <= '0;
      Busy       <= '0;
      cfg_loop   <= '0;
      act_loop   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cfg_base[c] <= '0;
        cfg_len[c]  <= '0;
        act_base[c] <= '0;
        act_len[c]  <= '0;
        pos[c]      <= '0;
        note[c]     <= '0;
      end
    end else begin
      pending    <= pend_nxt;
      NoteStrobe <= '0;
      Done       <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        if (CfgWe && (CfgChan == 3'(c))) begin
          cfg_base[c] <= CfgBase;
          cfg_len[c]  <= CfgLen;
          cfg_loop[c] <= CfgLoop;
        end
        if (Stop[c]) begin
          Busy[c] <= 1'b0;
          note[c] <= '0;
        end else if (go[c]) begin
          Busy[c]     <= 1'b1;
          pos[c]      <= '0;
          note[c]     <= '0;
          act_base[c] <= cfg_base[c];
          act_len[c]  <= cfg_len[c];
          act_loop[c] <= cfg_loop[c];
        end else begin
          // capture and advance never coincide: a channel being fetched is still pending
          if (capture[c]) begin
            note[c]       <= MemData;
            NoteStrobe[c] <= 1'b1;
            pos[c]        <= pos[c] + POS_ONE;
          end
          if (advance[c] && !(pos[c] < {1'b0, act_len[c]})) begin
            if (act_loop[c]) begin
              pos[c] <= '0;
            end else begin
              Busy[c] <= 1'b0;
              note[c] <= '0;
              Done[c] <= 1'b1;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_note
    assign Note[g*NOTE_W +: NOTE_W] = note[g];
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_sequencer.sv
// Self-checking bench for audio_sequencer: directed scenarios plus random traffic
// compared every cycle against a rule-level reference model.
`default_nettype none

module tb_audio_sequencer;
  localparam int CH = 4;
  localparam int NW = 8;
  localparam int AW = 10;
  localparam int LW = 8;
  localparam int DW = 25;

  logic            CLK = 1'b0;
  logic            Reset = 1'b0;
  logic [DW-1:0]   TempoDiv;
  logic            CfgWe;
  logic [2:0]      CfgChan;
  logic [AW-1:0]   CfgBase;
  logic [LW-1:0]   CfgLen;
  logic            CfgLoop;
  logic [CH-1:0]   Start, Stop;
  logic            MemRd;
  logic [AW-1:0]   MemAddr;
  logic [NW-1:0]   MemData = '0;
  logic [CH*NW-1:0] Note;
  logic [CH-1:0]   NoteStrobe, Busy, Done;

  audio_sequencer #(.CHANNELS(CH), .NOTE_W(NW), .ADDR_W(AW), .LEN_W(LW), .DIV_W(DW)) dut (
    .CLK(CLK), .Reset(Reset), .TempoDiv(TempoDiv), .CfgWe(CfgWe), .CfgChan(CfgChan),
    .CfgBase(CfgBase), .CfgLen(CfgLen), .CfgLoop(CfgLoop), .Start(Start), .Stop(Stop),
    .MemRd(MemRd), .MemAddr(MemAddr), .MemData(MemData), .Note(Note),
    .NoteStrobe(NoteStrobe), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  logic [7:0] mem [1024];
  always @(posedge CLK) if (MemRd) MemData <= mem[MemAddr];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int   m_cnt;
  int   cfg_base [CH], cfg_len [CH], a_base [CH], a_len [CH], m_pos [CH];
  bit   cfg_loop [CH], a_loop [CH], m_busy [CH], m_pend [CH], m_strobe [CH], m_done [CH];
  int   m_note [CH];
  int   f_phase, f_ch, f_addr;  // f_phase: 0 none, 1 address on bus, 2 data returning
  bit   f_dead;

  // observation records for directed checks
  int   rec_note0[$], rec_cyc0[$], rec_addr[$];
  int   done_cnt [CH];
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; f_phase = 0; f_ch = 0; f_addr = 0; f_dead = 0;
    for (int c = 0; c < CH; c++) begin
      cfg_base[c] = 0; cfg_len[c] = 0; cfg_loop[c] = 0;
      a_base[c] = 0; a_len[c] = 0; a_loop[c] = 0; m_pos[c] = 0;
      m_busy[c] = 0; m_pend[c] = 0; m_strobe[c] = 0; m_done[c] = 0; m_note[c] = 0;
    end
  endtask

  task automatic model_update();
    bit tick, old_p;
    int cap_ch, cap_d, pick;
    bit go [CH];
    bit kill [CH];
    tick   = (m_cnt >= int'(TempoDiv));
    m_cnt  = tick ? 0 : m_cnt + 1;
    cap_ch = (f_phase == 2 && !f_dead) ? f_ch : -1;
    cap_d  = int'(mem[f_addr]);
    for (int c = 0; c < CH; c++) begin
      go[c]   = Start[c] && !Stop[c] && cfg_len[c] != 0;
      kill[c] = Stop[c] || go[c];
    end
    if (f_phase == 1) begin
      f_addr = (a_base[f_ch] + m_pos[f_ch]) % 1024;
      f_dead = kill[f_ch];
    end
    for (int c = 0; c < CH; c++) begin
      old_p = m_pend[c];
      m_strobe[c] = 0; m_done[c] = 0;
      if (Stop[c]) begin
        m_busy[c] = 0; m_note[c] = 0; m_pend[c] = 0;
      end else if (go[c]) begin
        m_busy[c] = 1; m_pos[c] = 0; m_note[c] = 0; m_pend[c] = tick;
        a_base[c] = cfg_base[c]; a_len[c] = cfg_len[c]; a_loop[c] = cfg_loop[c];
      end else begin
        if (cap_ch == c) begin
          m_note[c] = cap_d; m_strobe[c] = 1; m_pos[c]++; m_pend[c] = 0;
        end
        if (tick && m_busy[c] && !old_p) begin
          if (m_pos[c] < a_len[c]) m_pend[c] = 1;
          else if (a_loop[c]) begin m_pos[c] = 0; m_pend[c] = 1; end
          else begin m_busy[c] = 0; m_note[c] = 0; m_done[c] = 1; end
        end
      end
    end
    if (CfgWe && int'(CfgChan) < CH) begin
      cfg_base[CfgChan] = int'(CfgBase);
      cfg_len[CfgChan]  = int'(CfgLen);
      cfg_loop[CfgChan] = CfgLoop;
    end
    case (f_phase)
      0: begin
        pick = -1;
        for (int c = CH - 1; c >= 0; c--) if (m_pend[c]) pick = c;
        if (pick >= 0) begin f_ch = pick; f_phase = 1; end
      end
      1: f_phase = 2;
      default: f_phase = 0;
    endcase
  endtask

  task automatic compare_all();
    logic [31:0] en;
    logic [3:0]  es, eb, ed;
    en = '0; es = '0; eb = '0; ed = '0;
    for (int c = 0; c < CH; c++) begin
      en[c*NW +: NW] = NW'(m_note[c]);
      es[c] = m_strobe[c]; eb[c] = m_busy[c]; ed[c] = m_done[c];
    end
    chk("note", Note, en);
    chk("strobe", 32'(NoteStrobe), 32'(es));
    chk("busy", 32'(Busy), 32'(eb));
    chk("done", 32'(Done), 32'(ed));
    chk("memrd", 32'(MemRd), 32'(f_phase == 1));
    chk("memaddr", 32'(MemAddr), (f_phase == 1) ? 32'((a_base[f_ch] + m_pos[f_ch]) % 1024) : 32'd0);
  endtask

  task automatic step();
    compare_all();
    if (NoteStrobe[0]) begin rec_note0.push_back(int'(Note[7:0])); rec_cyc0.push_back(cyc); end
    if (MemRd) rec_addr.push_back(int'(MemAddr));
    for (int c = 0; c < CH; c++) if (Done[c]) done_cnt[c]++;
    model_update();
    @(posedge CLK); #1;
    cyc++;
    Start = '0; Stop = '0; CfgWe = 1'b0;
  endtask

  task automatic cfg(input int ch, input int base, input int len, input bit loop);
    CfgWe = 1'b1; CfgChan = 3'(ch); CfgBase = AW'(base); CfgLen = LW'(len); CfgLoop = loop;
    step();
  endtask

  task automatic wait_memrd(input string tag);
    for (int i = 0; i < 60 && !MemRd; i++) step();
    chk(tag, 32'(MemRd), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h010] = 8'h11; mem[10'h011] = 8'h22; mem[10'h012] = 8'h33;
    TempoDiv = DW'(19); CfgWe = 0; CfgChan = 0; CfgBase = 0; CfgLen = 0; CfgLoop = 0;
    Start = '0; Stop = '0;
    for (int c = 0; c < CH; c++) done_cnt[c] = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_note", Note, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_memrd", 32'(MemRd), 32'd0);
    chk("rst_memaddr", 32'(MemAddr), 32'd0);
    Reset = 1'b1;

    // single channel loop
    cfg(0, 'h010, 3, 1);
    Start = 4'b0001;
    step();
    repeat (100) step();
    chk("loop_cnt", 32'(rec_note0.size() >= 4), 32'd1);
    if (rec_note0.size() >= 4) begin
      chk("loop_n0", 32'(rec_note0[0]), 32'h11);
      chk("loop_n1", 32'(rec_note0[1]), 32'h22);
      chk("loop_n2", 32'(rec_note0[2]), 32'h33);
      chk("loop_n3", 32'(rec_note0[3]), 32'h11);
      chk("loop_period", 32'(rec_cyc0[1] - rec_cyc0[0]), 32'd20);
    end
    chk("loop_nodone", 32'(done_cnt[0]), 32'd0);

    // one-shot with address wrap
    Stop = 4'b0001;
    step();
    cfg(1, 'h3FE, 3, 0);
    rec_addr.delete();
    Start = 4'b0010;
    step();
    repeat (100) step();
    chk("os_nreads", 32'(rec_addr.size()), 32'd3);
    if (rec_addr.size() == 3) begin
      chk("os_a0", 32'(rec_addr[0]), 32'h3FE);
      chk("os_a1", 32'(rec_addr[1]), 32'h3FF);
      chk("os_a2", 32'(rec_addr[2]), 32'h000);
    end
    chk("os_done", 32'(done_cnt[1]), 32'd1);
    chk("os_busy", 32'(Busy[1]), 32'd0);

    // arbitration, then overrun
    TempoDiv = DW'(11);
    for (int c = 0; c < CH; c++) cfg(c, int'($urandom_range(0, 1023)), 3, 1);
    Start = 4'b1111;
    step();
    repeat (80) step();
    TempoDiv = DW'(5);
    repeat (80) step();
    Stop = 4'b1111;
    step();

    // stop during capture, then simultaneous start/stop
    TempoDiv = DW'(15);
    cfg(2, 'h200, 2, 1);
    Start = 4'b0100;
    step();
    wait_memrd("wait_issue2");
    step();
    Stop = 4'b0100;
    step();
    chk("stop_strobe", 32'(NoteStrobe[2]), 32'd0);
    chk("stop_note", 32'(Note[23:16]), 32'd0);
    chk("stop_busy", 32'(Busy[2]), 32'd0);
    chk("stop_done", 32'(Done[2]), 32'd0);
    Start = 4'b0100; Stop = 4'b0100;
    step();
    chk("startstop_busy", 32'(Busy[2]), 32'd0);

    // config shadowing and zero length
    cfg(0, 'h100, 3, 1);
    Start = 4'b0001;
    step();
    repeat (10) step();
    cfg(0, 'h100, 1, 1);
    rec_addr.delete();
    repeat (60) step();
    chk("shadow_old", 32'(rec_addr.size() >= 3 && rec_addr[0] != rec_addr[1]), 32'd1);
    Start = 4'b0001;
    step();
    rec_addr.delete();
    repeat (70) step();
    chk("shadow_new_cnt", 32'(rec_addr.size() >= 3), 32'd1);
    foreach (rec_addr[i]) chk("shadow_new_addr", 32'(rec_addr[i]), 32'h100);
    cfg(3, 'h000, 0, 0);
    Start = 4'b1000;
    step();
    chk("len0_busy", 32'(Busy[3]), 32'd0);

    // asynchronous reset in the middle of a fetch
    wait_memrd("wait_issue0");
    Reset = 1'b0;
    #1;
    chk("arst_memrd", 32'(MemRd), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd0);
    chk("arst_note", Note, 32'd0);
    model_reset();
    @(posedge CLK); #1;
    Reset = 1'b1;
    repeat (50) step();
    chk("post_rst_idle", 32'(Busy), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0)
        TempoDiv = ($urandom_range(0, 3) == 0) ? DW'(5) : DW'($urandom_range(12, 30));
      if ($urandom_range(0, 9) == 0) begin
        CfgWe = 1'b1; CfgChan = 3'($urandom_range(0, 7));
        CfgBase = AW'($urandom); CfgLen = LW'($urandom_range(0, 5)); CfgLoop = 1'($urandom);
      end
      for (int c = 0; c < CH; c++) begin
        Start[c] = ($urandom_range(0, 39) == 0);
        Stop[c]  = ($urandom_range(0, 59) == 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
